// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop,
// adding LSB-first and presenting the result in parallel.

module half_add (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             hs1, hc1, fa_s, hc2, fa_c;
  logic [WIDTH-1:0] acc_shift;

  // Full adder built from two half adders on the LSBs and the carry flop.
  half_add u_ha0 (.x(a_sr_q[0]), .y(b_sr_q[0]), .s(hs1), .c(hc1));
  half_add u_ha1 (.x(hs1), .y(c_q), .s(fa_s), .c(hc2));
  assign fa_c = hc1 | hc2;

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at acc[0].
  assign acc_shift = WIDTH'({fa_s, acc_q} >> 1);

  // Next-state and datapath updates for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_sr_d  = a;
          b_sr_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        c_d    = fa_c;
        acc_d  = acc_shift;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = acc_shift;
          cout_d  = fa_c;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder (WIDTH=8 and WIDTH=1),
// checked every cycle against an arithmetic reference model.

module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic start1 = 1'b0;
  logic a1 = 1'b0;
  logic b1 = 1'b0;
  logic cin1 = 1'b0;
  logic busy1, done1, sum1, cout1;

  int n_chk = 0;
  int n_pass = 0;
  int n_done = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(1), .CW(4)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  // Reference model: busy for W+1 cycles per accepted op, result = a+b+cin.
  int         m_left;
  logic       m_done;
  logic [W:0] m_res;
  logic [W:0] m_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_out  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_left <= W + 1;
          m_res  <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 2) begin
          m_done <= 1'b1;
          m_out  <= m_res;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 64'(busy), 64'(m_left != 0));
      check("done", 64'(done), 64'(m_done));
      check("sum_cout", 64'({cout, sum}), 64'(m_out));
      if (done) n_done++;
    end
  end

  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                    input logic tc, output int lat, output int bsy);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0;
    bsy = busy ? 1 : 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bsy++;
      if (done) break;
    end
    if (!done) begin
      check("done_timeout", 64'(0), 64'(1));
      lat = -1;
    end
    @(posedge clk); #1;
    if (busy) bsy++;
  endtask

  initial begin
    int lat, bsy, d0;
    logic [1:0] e1;
    #2;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sum", 64'({cout, sum}), 64'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    op(8'h5A, 8'h3C, 1'b0, lat, bsy);
    check("5a3c_sum", 64'(sum), 64'h96);
    check("5a3c_cout", 64'(cout), 64'(0));
    check("5a3c_lat", 64'(lat), 64'(W));
    check("5a3c_busy_cycles", 64'(bsy), 64'(W + 1));

    op(8'hFF, 8'h01, 1'b0, lat, bsy);
    check("ff01_res", 64'({cout, sum}), 64'h100);
    op(8'hFF, 8'hFF, 1'b1, lat, bsy);
    check("ffff1_res", 64'({cout, sum}), 64'h1FF);

    // Start during SHIFT must be ignored.
    d0 = n_done;
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("ignore_sum", 64'(sum), 64'h96);
    check("ignore_one_done", 64'(n_done - d0), 64'(1));

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    start = 1'b1; a = 8'h77; b = 8'h22; cin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_sum", 64'({cout, sum}), 64'(0));
    d0 = n_done;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("arst_no_done", 64'(n_done - d0), 64'(0));
    op(8'hC3, 8'h4E, 1'b1, lat, bsy);
    check("after_rst_res", 64'({cout, sum}), 64'h112);

    // Back-to-back random operands with start held high.
    d0 = n_done;
    for (int i = 0; i < 220; i++) begin
      @(negedge clk);
      start = 1'b1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("b2b_done_count", 64'(n_done - d0 >= 20), 64'(1));

    // WIDTH=1 instance: exhaustive.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start1 = 1'b1;
      {a1, b1, cin1} = 3'(i);
      e1 = 2'(a1) + 2'(b1) + 2'(cin1);
      @(posedge clk); #1;
      start1 = 1'b0;
      lat = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        lat++;
        if (done1) break;
      end
      check("w1_lat", 64'(lat), 64'(1));
      check("w1_res", 64'({cout1, sum1}), 64'(e1));
      @(posedge clk); #1;
      check("w1_idle", 64'(busy1), 64'(0));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
